// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
// Arbitrates VGA pixel writes between the screen-clear engine and the
// tile-draw engine. The winner keeps a grant for a burst of up to MAX_BURST
// pixels. Accepted pixels are range-checked and then forwarded to the VGA
// adapter one cycle later. Out-of-range pixels are consumed and counted in a
// saturating drop counter.
module pixel_write_arbiter #(
   parameter int X_MAX     = 319,
   parameter int Y_MAX     = 239,
   parameter int MAX_BURST = 64
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       clr_req,
   input  logic [8:0] clr_x,
   input  logic [7:0] clr_y,
   input  logic [2:0] clr_colour,
   input  logic       tile_req,
   input  logic [8:0] tile_x,
   input  logic [7:0] tile_y,
   input  logic [2:0] tile_colour,
   output logic       clr_gnt,
   output logic       tile_gnt,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic [7:0] drop_count,
   output logic       busy
);

   localparam int              BW         = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [8:0]      X_LIM      = 9'(X_MAX);
   localparam logic [7:0]      Y_LIM      = 8'(Y_MAX);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT_CLR  = 2'd1,
      GRANT_TILE = 2'd2
   } state_t;

   state_t          state;
   logic [BW-1:0]   burst_cnt;
   logic            fair_tile;

   logic            acc_p0;
   logic            last_p0;
   logic            in_range_p0;
   logic [8:0]      sel_x_p0;
   logic [7:0]      sel_y_p0;
   logic [2:0]      sel_colour_p0;

   // Saturating increment: the drop counter sticks at its maximum value
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Stage p0: decide acceptance and select the owner's pixel
   always_comb begin
      acc_p0        = 1'b0;
      sel_x_p0      = clr_x;
      sel_y_p0      = clr_y;
      sel_colour_p0 = clr_colour;
      if (state == GRANT_CLR) begin
         acc_p0 = clr_req;
      end else if (state == GRANT_TILE) begin
         acc_p0        = tile_req;
         sel_x_p0      = tile_x;
         sel_y_p0      = tile_y;
         sel_colour_p0 = tile_colour;
      end
      in_range_p0 = (sel_x_p0 <= X_LIM) && (sel_y_p0 <= Y_LIM);
      last_p0     = acc_p0 && (burst_cnt == BURST_LAST);
   end

   // Grant FSM: fixed clear priority, burst limit, one-shot tile fairness
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         clr_gnt   <= 1'b0;
         tile_gnt  <= 1'b0;
         busy      <= 1'b0;
         burst_cnt <= '0;
         fair_tile <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               burst_cnt <= '0;
               if (fair_tile && tile_req) begin
                  state     <= GRANT_TILE;
                  tile_gnt  <= 1'b1;
                  busy      <= 1'b1;
                  fair_tile <= 1'b0;
               end else if (clr_req) begin
                  state     <= GRANT_CLR;
                  clr_gnt   <= 1'b1;
                  busy      <= 1'b1;
                  fair_tile <= 1'b0;
               end else if (tile_req) begin
                  state     <= GRANT_TILE;
                  tile_gnt  <= 1'b1;
                  busy      <= 1'b1;
                  fair_tile <= 1'b0;
               end
            end
            GRANT_CLR: begin
               if (!clr_req || last_p0) begin
                  state     <= IDLE;
                  clr_gnt   <= 1'b0;
                  busy      <= 1'b0;
                  burst_cnt <= '0;
                  // A full clear burst gives the tile engine the next turn
                  if (last_p0) fair_tile <= 1'b1;
               end else begin
                  burst_cnt <= burst_cnt + BW'(1);
               end
            end
            GRANT_TILE: begin
               if (!tile_req || last_p0) begin
                  state     <= IDLE;
                  tile_gnt  <= 1'b0;
                  busy      <= 1'b0;
                  burst_cnt <= '0;
               end else begin
                  burst_cnt <= burst_cnt + BW'(1);
               end
            end
            default: begin
               state     <= IDLE;
               clr_gnt   <= 1'b0;
               tile_gnt  <= 1'b0;
               busy      <= 1'b0;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   // Stage p1: register in-range pixels for the VGA adapter, count drops
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         drop_count <= '0;
      end else begin
         vga_plot <= acc_p0 && in_range_p0;
         if (acc_p0 && in_range_p0) begin
            vga_x      <= sel_x_p0;
            vga_y      <= sel_y_p0;
            vga_colour <= sel_colour_p0;
         end
         if (acc_p0 && !in_range_p0) begin
            drop_count <= sat_inc8(drop_count);
         end
      end
   end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter with hand-computed expectations.
module tb_pixel_write_arbiter;

   logic       clock = 1'b0;
   logic       resetn;
   logic       clr_req;
   logic [8:0] clr_x;
   logic [7:0] clr_y;
   logic [2:0] clr_colour;
   logic       tile_req;
   logic [8:0] tile_x;
   logic [7:0] tile_y;
   logic [2:0] tile_colour;
   logic       clr_gnt;
   logic       tile_gnt;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic [7:0] drop_count;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   pixel_write_arbiter #(.X_MAX(319), .Y_MAX(239), .MAX_BURST(64)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .clr_req    (clr_req),
      .clr_x      (clr_x),
      .clr_y      (clr_y),
      .clr_colour (clr_colour),
      .tile_req   (tile_req),
      .tile_x     (tile_x),
      .tile_y     (tile_y),
      .tile_colour(tile_colour),
      .clr_gnt    (clr_gnt),
      .tile_gnt   (tile_gnt),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .drop_count (drop_count),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      chk("gnt_exclusive", {31'd0, clr_gnt & tile_gnt}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] last_x;
      logic        exp_g;
      logic        exp_p;

      resetn = 1'b0;
      clr_req = 1'b0; clr_x = '0; clr_y = '0; clr_colour = '0;
      tile_req = 1'b0; tile_x = '0; tile_y = '0; tile_colour = '0;
      #12;
      chk("rst_clr_gnt", {31'd0, clr_gnt}, 0);
      chk("rst_tile_gnt", {31'd0, tile_gnt}, 0);
      chk("rst_plot", {31'd0, vga_plot}, 0);
      chk("rst_vga_x", {23'd0, vga_x}, 0);
      chk("rst_drop", {24'd0, drop_count}, 0);
      chk("rst_busy", {31'd0, busy}, 0);

      // Streaming clear: x 120.., y 0, colour 7
      clr_req = 1'b1; clr_x = 9'd120; clr_y = 8'd0; clr_colour = 3'd7;
      @(negedge clock);
      resetn = 1'b1;
      last_x = 32'd0;
      for (int n = 1; n <= 68; n++) begin
         if (n <= 2)       clr_x = 9'd120;
         else if (n <= 65) clr_x = 9'(118 + n);
         else if (n <= 67) clr_x = 9'd184;
         else              clr_x = 9'd185;
         tick();
         exp_g = (n <= 64) || (n >= 66);
         exp_p = (n >= 2 && n <= 65) || (n >= 67);
         if (exp_p) last_x = (n <= 65) ? 32'(118 + n) : 32'(184 + n - 67);
         chk("stream_clr_gnt", {31'd0, clr_gnt}, {31'd0, exp_g});
         chk("stream_plot", {31'd0, vga_plot}, {31'd0, exp_p});
         chk("stream_vga_x", {23'd0, vga_x}, last_x);
         chk("stream_busy", {31'd0, busy}, {31'd0, exp_g});
      end
      chk("stream_vga_y", {24'd0, vga_y}, 0);
      chk("stream_colour", {29'd0, vga_colour}, 7);
      clr_req = 1'b0;
      tick();
      chk("release_gnt", {31'd0, clr_gnt}, 0);
      chk("release_plot", {31'd0, vga_plot}, 0);
      chk("release_hold_x", {23'd0, vga_x}, 185);

      // Simultaneous requests: clear first, tile after a full clear burst
      clr_x = 9'd10; clr_y = 8'd5; clr_colour = 3'd1;
      tile_x = 9'd20; tile_y = 8'd6; tile_colour = 3'd2;
      clr_req = 1'b1; tile_req = 1'b1;
      for (int n = 1; n <= 66; n++) begin
         tick();
         if (n == 1) begin
            chk("prio_clr_gnt", {31'd0, clr_gnt}, 1);
            chk("prio_tile_gnt", {31'd0, tile_gnt}, 0);
         end
         if (n == 65) begin
            chk("burst_end_clr", {31'd0, clr_gnt}, 0);
            chk("burst_end_tile", {31'd0, tile_gnt}, 0);
         end
         if (n == 66) begin
            chk("fair_tile_gnt", {31'd0, tile_gnt}, 1);
            chk("fair_clr_gnt", {31'd0, clr_gnt}, 0);
         end
      end
      tick();
      chk("tile_plot", {31'd0, vga_plot}, 1);
      chk("tile_x", {23'd0, vga_x}, 20);
      chk("tile_y", {24'd0, vga_y}, 6);
      chk("tile_colour", {29'd0, vga_colour}, 2);
      tile_req = 1'b0;
      tick();
      chk("tile_drop_gnt", {31'd0, tile_gnt}, 0);
      chk("tile_drop_plot", {31'd0, vga_plot}, 0);
      tile_req = 1'b1;
      tick();
      chk("revert_clr_gnt", {31'd0, clr_gnt}, 1);
      chk("revert_tile_gnt", {31'd0, tile_gnt}, 0);

      // Owner request gap mid-burst restarts the burst count
      repeat (10) tick();
      clr_req = 1'b0;
      tick();
      chk("gap_gnt", {31'd0, clr_gnt}, 0);
      chk("gap_plot", {31'd0, vga_plot}, 0);
      clr_req = 1'b1;
      tick();
      chk("regrant_clr", {31'd0, clr_gnt}, 1);
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k == 54) chk("restart_k54", {31'd0, clr_gnt}, 1);
         if (k == 63) chk("restart_k63", {31'd0, clr_gnt}, 1);
         if (k == 64) chk("restart_k64", {31'd0, clr_gnt}, 0);
      end
      tick();
      chk("fair2_tile_gnt", {31'd0, tile_gnt}, 1);
      clr_req = 1'b0; tile_req = 1'b0;
      tick();
      chk("idle_busy", {31'd0, busy}, 0);
      chk("no_drops_yet", {24'd0, drop_count}, 0);

      // Range boundaries on the tile port
      tile_req = 1'b1; tile_x = 9'd320; tile_y = 8'd10; tile_colour = 3'd5;
      tick();
      tick();
      chk("x320_plot", {31'd0, vga_plot}, 0);
      chk("x320_drop", {24'd0, drop_count}, 1);
      tile_x = 9'd319; tile_y = 8'd239;
      tick();
      chk("edge_plot", {31'd0, vga_plot}, 1);
      chk("edge_x", {23'd0, vga_x}, 319);
      chk("edge_y", {24'd0, vga_y}, 239);
      chk("edge_colour", {29'd0, vga_colour}, 5);
      chk("edge_drop", {24'd0, drop_count}, 1);
      tile_x = 9'd0; tile_y = 8'd240;
      tick();
      chk("y240_plot", {31'd0, vga_plot}, 0);
      chk("y240_drop", {24'd0, drop_count}, 2);
      chk("y240_hold_x", {23'd0, vga_x}, 319);
      tile_req = 1'b0;
      tick();
      chk("range_idle", {31'd0, tile_gnt}, 0);

      // Drop counter saturation
      tile_req = 1'b1; tile_x = 9'd400; tile_y = 8'd0;
      for (int n = 1; n <= 258; n++) begin
         tick();
         if (n == 65)  chk("drop_66", {24'd0, drop_count}, 66);
         if (n == 100) chk("drop_noplot", {31'd0, vga_plot}, 0);
         if (n == 256) chk("drop_254", {24'd0, drop_count}, 254);
         if (n == 257) chk("drop_255", {24'd0, drop_count}, 255);
         if (n == 258) chk("drop_sat", {24'd0, drop_count}, 255);
      end
      tile_req = 1'b0;
      tick();

      // Reset asserted in the middle of a tile burst
      tile_x = 9'd5; tile_y = 8'd5; tile_colour = 3'd3; tile_req = 1'b1;
      tick();
      tick();
      tick();
      chk("pre_rst_plot", {31'd0, vga_plot}, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_tile_gnt", {31'd0, tile_gnt}, 0);
      chk("arst_clr_gnt", {31'd0, clr_gnt}, 0);
      chk("arst_plot", {31'd0, vga_plot}, 0);
      chk("arst_x", {23'd0, vga_x}, 0);
      chk("arst_y", {24'd0, vga_y}, 0);
      chk("arst_colour", {29'd0, vga_colour}, 0);
      chk("arst_drop", {24'd0, drop_count}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      tick();
      chk("rst_hold_gnt", {31'd0, tile_gnt}, 0);
      chk("rst_hold_plot", {31'd0, vga_plot}, 0);
      @(negedge clock);
      resetn = 1'b1;
      tick();
      chk("post_rst_gnt", {31'd0, tile_gnt}, 1);
      chk("post_rst_plot", {31'd0, vga_plot}, 0);
      tick();
      chk("post_rst_plot2", {31'd0, vga_plot}, 1);
      chk("post_rst_x", {23'd0, vga_x}, 5);
      chk("post_rst_busy", {31'd0, busy}, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
